// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - receive frame controller: packet-buffer writer, descriptor and space accounting
//
// Writes incoming frame bytes into a circular packet buffer, commits good frames
// as a single-entry descriptor, and rewinds the write pointer on dropped frames.
//
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   begin_packet        start-of-frame flag from the RX parser
//   end_packet          end-of-frame flag from the RX parser
//   packet_data         frame byte, qualified by data_ready
//   data_ready          packet_data valid this cycle
//   buf_wr_en/addr/data packet-buffer write port (combinational from wp)
//   desc_valid/addr/len committed-frame descriptor, held until desc_ready
//   desc_ready          consumer takes the descriptor
//   free_valid/free_len consumer returns buffer space
//   frames_ok/drop      saturating frame counters
module rx_frame_ctrl #(
  parameter int ADDR_W  = 11,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              begin_packet,
  input  logic              end_packet,
  input  logic [7:0]        packet_data,
  input  logic              data_ready,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [7:0]        buf_wr_data,
  output logic              desc_valid,
  output logic [ADDR_W-1:0] desc_addr,
  output logic [ADDR_W-1:0] desc_len,
  input  logic              desc_ready,
  input  logic              free_valid,
  input  logic [ADDR_W-1:0] free_len,
  output logic [15:0]       frames_ok,
  output logic [15:0]       frames_drop
);

  // Two extra bits so used + len can be formed without overflow.
  localparam int CW = ADDR_W + 2;
  localparam logic [CW-1:0]     DEPTH = {2'b01, {ADDR_W{1'b0}}};
  localparam logic [CW-1:0]     MIN_C = CW'(MIN_LEN);
  localparam logic [CW-1:0]     MAX_C = CW'(MAX_LEN);
  localparam logic [CW-1:0]     L_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, RECV, COMMIT, DROP, WAIT_DESC, DISCARD
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] wp, wp_n;
  logic [ADDR_W-1:0] start, start_n;
  logic [CW-1:0]     len, len_n;
  logic [CW-1:0]     used, used_n;
  logic              pend_begin, pend_begin_n;
  logic              pend_end, pend_end_n;

  logic              wr_en;
  logic              do_commit;
  logic              do_drop;
  logic              blocked;
  logic              aborted_end;
  logic [CW-1:0]     cur_len;
  logic [CW-1:0]     len_fin;
  logic [CW-1:0]     used_add;
  logic [CW-1:0]     free_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    wp_n         = wp;
    start_n      = start;
    len_n        = len;
    pend_begin_n = pend_begin;
    pend_end_n   = pend_end;
    wr_en        = 1'b0;
    do_commit    = 1'b0;
    do_drop      = 1'b0;
    blocked      = 1'b0;
    // IDLE handles the begin_packet cycle exactly like a RECV cycle with len 0,
    // so a byte (and even end_packet) arriving with begin_packet is processed.
    cur_len      = (state == IDLE) ? '0 : len;
    len_fin      = cur_len;
    // A frame that began while the descriptor slot was busy: has it already ended?
    aborted_end  = pend_end | (end_packet & (pend_begin | begin_packet));

    case (state)
      IDLE, RECV: begin
        if (state == RECV && begin_packet) begin
          state_n = DROP;
        end else if (state == RECV || begin_packet) begin
          if (state == IDLE) start_n = wp;
          if (data_ready) begin
            // Giant (next byte would exceed MAX_LEN) or no free space left.
            if (cur_len == MAX_C || (used + cur_len) >= DEPTH) begin
              blocked = 1'b1;
            end else begin
              wr_en   = 1'b1;
              wp_n    = wp + A_ONE;
              len_fin = cur_len + L_ONE;
            end
          end
          len_n = len_fin;
          if (blocked) begin
            state_n = end_packet ? DROP : DISCARD;
          end else if (end_packet) begin
            state_n = (len_fin >= MIN_C && len_fin <= MAX_C) ? COMMIT : DROP;
          end else begin
            state_n = RECV;
          end
        end
      end
      COMMIT, WAIT_DESC: begin
        if (begin_packet) pend_begin_n = 1'b1;
        if (end_packet && (pend_begin || begin_packet)) pend_end_n = 1'b1;
        if (!desc_valid) begin
          do_commit    = 1'b1;
          // Keep the committed bytes: a following DROP rewinds only to here.
          start_n      = wp;
          pend_begin_n = 1'b0;
          pend_end_n   = 1'b0;
          if (pend_begin || begin_packet) begin
            state_n = aborted_end ? DROP : DISCARD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = WAIT_DESC;
        end
      end
      DISCARD: begin
        if (end_packet) state_n = DROP;
      end
      DROP: begin
        wp_n    = start;
        do_drop = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Commit and release may land on the same edge; both apply, floor at zero.
  always_comb begin
    used_add = used + (do_commit ? len : '0);
    free_ext = {2'b00, free_len};
    used_n   = used_add;
    if (free_valid) begin
      used_n = (free_ext > used_add) ? '0 : (used_add - free_ext);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp          <= '0;
      start       <= '0;
      len         <= '0;
      used        <= '0;
      pend_begin  <= 1'b0;
      pend_end    <= 1'b0;
      desc_valid  <= 1'b0;
      desc_addr   <= '0;
      desc_len    <= '0;
      frames_ok   <= '0;
      frames_drop <= '0;
    end else begin
      wp         <= wp_n;
      start      <= start_n;
      len        <= len_n;
      used       <= used_n;
      pend_begin <= pend_begin_n;
      pend_end   <= pend_end_n;
      if (do_commit) begin
        desc_valid <= 1'b1;
        desc_addr  <= start;
        desc_len   <= len[ADDR_W-1:0];
      end else if (desc_valid && desc_ready) begin
        desc_valid <= 1'b0;
      end
      if (do_commit && frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
      if (do_drop && frames_drop != 16'hFFFF) frames_drop <= frames_drop + 16'd1;
    end
  end

  // Gated by reset so the strobe drops the instant reset asserts.
  assign buf_wr_en   = wr_en & reset;
  assign buf_wr_addr = wp;
  assign buf_wr_data = packet_data;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - self-checking bench for rx_frame_ctrl
module tb_rx_frame_ctrl;
  localparam int ADDR_W  = 11;
  localparam int DEPTH   = 2048;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic              clk = 1'b0;
  logic              reset;
  logic              begin_packet, end_packet, data_ready;
  logic [7:0]        packet_data;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [7:0]        buf_wr_data;
  logic              desc_valid;
  logic [ADDR_W-1:0] desc_addr, desc_len;
  logic              desc_ready, free_valid;
  logic [ADDR_W-1:0] free_len;
  logic [15:0]       frames_ok, frames_drop;

  always #5 clk = ~clk;

  rx_frame_ctrl dut (
    .clk(clk), .reset(reset),
    .begin_packet(begin_packet), .end_packet(end_packet),
    .packet_data(packet_data), .data_ready(data_ready),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .desc_valid(desc_valid), .desc_addr(desc_addr), .desc_len(desc_len),
    .desc_ready(desc_ready), .free_valid(free_valid), .free_len(free_len),
    .frames_ok(frames_ok), .frames_drop(frames_drop)
  );

  int errors = 0;
  int checks = 0;

  logic              s_wr_en;
  logic [ADDR_W-1:0] s_wr_addr;
  logic [7:0]        s_wr_data;
  logic              s_desc_valid;
  logic [ADDR_W-1:0] s_desc_addr, s_desc_len;
  logic [15:0]       s_ok, s_drop;

  typedef struct {
    int len;
    int gap;
    int exp_wr;
    bit exp_commit;
    int exp_addr;
    int exp_ok;
    int exp_drop;
    int free_amt;
  } vec_t;
  vec_t vecs[7];

  int wp_m, used_m, ok_m, drop_m;
  int outstanding[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: sample outputs at the falling edge, then let the rising edge pass.
  task automatic step();
    @(negedge clk);
    s_wr_en      = buf_wr_en;
    s_wr_addr    = buf_wr_addr;
    s_wr_data    = buf_wr_data;
    s_desc_valid = desc_valid;
    s_desc_addr  = desc_addr;
    s_desc_len   = desc_len;
    s_ok         = frames_ok;
    s_drop       = frames_drop;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
  endtask

  task automatic do_free(input int amt);
    free_valid = 1'b1;
    free_len   = ADDR_W'(amt);
    step();
    free_valid = 1'b0;
    free_len   = '0;
  endtask

  // Drive one frame; every write must land at exp_start+k (mod depth) with the byte sent.
  task automatic drive_frame(input int len, input int gapmax, input int exp_start,
                             input int exp_nwr, input string name);
    int nwr;
    int bad;
    int g;
    logic [7:0] b;
    nwr = 0;
    bad = 0;
    for (int k = 0; k < len; k++) begin
      g = 0;
      if (k > 0 && gapmax > 0 && $urandom_range(7, 0) == 0) g = $urandom_range(gapmax, 1);
      for (int j = 0; j < g; j++) begin
        begin_packet = 1'b0;
        end_packet   = 1'b0;
        data_ready   = 1'b0;
        step();
        if (s_wr_en) begin
          bad++;
          nwr++;
        end
      end
      b            = 8'($urandom);
      begin_packet = (k == 0);
      end_packet   = (k == len - 1);
      data_ready   = 1'b1;
      packet_data  = b;
      step();
      if (s_wr_en) begin
        if (int'(s_wr_addr) != (exp_start + nwr) % DEPTH || s_wr_data != b) bad++;
        nwr++;
      end
    end
    begin_packet = 1'b0;
    end_packet   = 1'b0;
    data_ready   = 1'b0;
    check({name, " write count"}, nwr, exp_nwr);
    check({name, " bad writes"}, bad, 0);
  endtask

  task automatic wait_desc(input int ea, input int el, input bit accept, input string name);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      found = s_desc_valid;
    end
    check({name, " desc_valid"}, int'(found), 1);
    check({name, " desc_addr"}, int'(s_desc_addr), ea);
    check({name, " desc_len"}, int'(s_desc_len), el);
    if (accept) begin
      desc_ready = 1'b1;
      step();
      desc_ready = 1'b0;
      step();
      check({name, " desc_valid cleared"}, int'(s_desc_valid), 0);
    end
  endtask

  task automatic no_desc(input string name);
    idle(4);
    check({name, " no descriptor"}, int'(s_desc_valid), 0);
  endtask

  task automatic check_counts(input int ok, input int drop, input string name);
    check({name, " frames_ok"}, int'(s_ok), ok);
    check({name, " frames_drop"}, int'(s_drop), drop);
  endtask

  initial begin
    reset        = 1'b0;
    begin_packet = 1'b0;
    end_packet   = 1'b0;
    data_ready   = 1'b0;
    packet_data  = '0;
    desc_ready   = 1'b0;
    free_valid   = 1'b0;
    free_len     = '0;
    idle(2);
    check("reset buf_wr_en", int'(s_wr_en), 0);
    check("reset desc_valid", int'(s_desc_valid), 0);
    check("reset desc_addr", int'(s_desc_addr), 0);
    check("reset desc_len", int'(s_desc_len), 0);
    check_counts(0, 0, "reset");
    reset = 1'b1;
    idle(2);

    // Frame table from reset: {len, gap, writes, commit, start addr, ok, drop, free after}
    vecs[0] = '{63,   1, 63,   1'b0, 0,    0, 1, 0};
    vecs[1] = '{64,   0, 64,   1'b1, 0,    1, 1, 64};
    vecs[2] = '{1519, 0, 1518, 1'b0, 64,   1, 2, 0};
    vecs[3] = '{64,   2, 64,   1'b1, 64,   2, 2, 0};
    vecs[4] = '{1518, 0, 1518, 1'b1, 128,  3, 2, 1518};
    vecs[5] = '{1,    0, 1,    1'b0, 1646, 3, 3, 0};
    vecs[6] = '{100,  1, 100,  1'b1, 1646, 4, 3, 0};
    for (int i = 0; i < 7; i++) begin
      drive_frame(vecs[i].len, vecs[i].gap, vecs[i].exp_addr, vecs[i].exp_wr,
                  $sformatf("vec%0d", i));
      if (vecs[i].exp_commit) wait_desc(vecs[i].exp_addr, vecs[i].len, 1'b1, $sformatf("vec%0d", i));
      else no_desc($sformatf("vec%0d", i));
      idle(2);
      check_counts(vecs[i].exp_ok, vecs[i].exp_drop, $sformatf("vec%0d", i));
      if (vecs[i].free_amt != 0) do_free(vecs[i].free_amt);
      idle(2);
    end

    // Descriptor back-pressure, and a frame arriving while the commit waits.
    apply_reset();
    drive_frame(100, 0, 0, 100, "bp1");
    wait_desc(0, 100, 1'b0, "bp1");
    idle(3);
    drive_frame(100, 0, 100, 100, "bp2");
    idle(3);
    check("bp held desc_valid", int'(s_desc_valid), 1);
    check("bp held desc_addr", int'(s_desc_addr), 0);
    check("bp held desc_len", int'(s_desc_len), 100);
    drive_frame(64, 0, 200, 0, "bp3");
    idle(3);
    check_counts(1, 0, "bp waiting");
    desc_ready = 1'b1;
    step();
    desc_ready = 1'b0;
    wait_desc(100, 100, 1'b1, "bp2 release");
    idle(2);
    check_counts(2, 1, "bp released");
    drive_frame(64, 0, 200, 64, "bp4");
    wait_desc(200, 64, 1'b1, "bp4");
    idle(2);
    check_counts(3, 1, "bp4");

    // Buffer full, then release and wrap.
    apply_reset();
    drive_frame(1000, 0, 0, 1000, "fill1");
    wait_desc(0, 1000, 1'b1, "fill1");
    drive_frame(1000, 0, 1000, 1000, "fill2");
    wait_desc(1000, 1000, 1'b1, "fill2");
    drive_frame(100, 0, 2000, 48, "full");
    no_desc("full");
    check_counts(2, 1, "full");
    do_free(2000);
    idle(2);
    drive_frame(100, 1, 2000, 100, "wrap");
    wait_desc(2000, 100, 1'b0, "wrap");
    idle(2);
    check_counts(3, 1, "wrap");

    // Reset in the middle of a frame, with a descriptor still held.
    begin_packet = 1'b1;
    data_ready   = 1'b1;
    for (int k = 0; k < 30; k++) begin
      packet_data = 8'($urandom);
      step();
      begin_packet = 1'b0;
    end
    packet_data = 8'h5a;
    reset       = 1'b0;
    #1;
    check("midreset buf_wr_en", int'(buf_wr_en), 0);
    check("midreset desc_valid", int'(desc_valid), 0);
    check("midreset desc_addr", int'(desc_addr), 0);
    check("midreset desc_len", int'(desc_len), 0);
    check("midreset frames_ok", int'(frames_ok), 0);
    check("midreset frames_drop", int'(frames_drop), 0);
    data_ready = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(2);
    drive_frame(64, 0, 0, 64, "after reset");
    wait_desc(0, 64, 1'b1, "after reset");
    idle(2);
    check_counts(1, 0, "after reset");

    // Randomised frames against a frame-level model of pointer and space accounting.
    apply_reset();
    wp_m   = 0;
    used_m = 0;
    ok_m   = 0;
    drop_m = 0;
    outstanding.delete();
    for (int f = 0; f < 30; f++) begin
      int len;
      int room;
      int nwr;
      int sel;
      int amt;
      bit commit;
      string nm;
      nm  = $sformatf("rnd%0d", f);
      sel = $urandom_range(9, 0);
      if (sel == 0) len = $urandom_range(MIN_LEN - 1, 1);
      else if (sel == 1) len = $urandom_range(MAX_LEN + 12, MAX_LEN + 1);
      else len = $urandom_range(MAX_LEN, MIN_LEN);
      room = DEPTH - used_m;
      nwr  = len;
      if (nwr > MAX_LEN) nwr = MAX_LEN;
      if (nwr > room) nwr = room;
      commit = (len >= MIN_LEN) && (len <= MAX_LEN) && (len <= room);
      drive_frame(len, 2, wp_m, nwr, nm);
      if (commit) begin
        wait_desc(wp_m, len, 1'b1, nm);
        wp_m   = (wp_m + len) % DEPTH;
        used_m = used_m + len;
        ok_m++;
        outstanding.push_back(len);
      end else begin
        no_desc(nm);
        drop_m++;
      end
      idle(1);
      check_counts(ok_m, drop_m, nm);
      amt = 0;
      if ($urandom_range(1, 0) == 1 && outstanding.size() > 0) begin
        amt = outstanding.pop_front();
      end else if ($urandom_range(7, 0) == 0) begin
        amt = $urandom_range(DEPTH - 1, 1);
        outstanding.delete();
      end
      if (amt != 0) begin
        do_free(amt);
        used_m = (amt > used_m) ? 0 : used_m - amt;
      end
      idle(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, 11, packet-buffer address width (depth 2^ADDR_W bytes); MIN_LEN, 64, smallest accepted frame in bytes; MAX_LEN, 1518, largest accepted frame in bytes.
REQ-002 Ports SHALL be (name direction width meaning):
clk  in  1  single clock, all logic rising-edge;
reset  in  1  asynchronous, active-low;
begin_packet  in  1  start-of-frame flag from GMII RX parser;
end_packet  in  1  end-of-frame flag from parser;
packet_data  in  8  frame byte;
data_ready  in  1  packet_data valid this cycle;
buf_wr_en  out  1  packet-buffer write strobe;
buf_wr_addr  out  ADDR_W  write address;
buf_wr_data  out  8  write byte;
desc_valid  out  1  committed-frame descriptor available;
desc_addr  out  ADDR_W  first-byte address of frame;
desc_len  out  ADDR_W  frame length in bytes;
desc_ready  in  1  consumer accepts descriptor;
free_valid  in  1  consumer releases buffer space;
free_len  in  ADDR_W  bytes released;
frames_ok  out  16  committed-frame counter;
frames_drop  out  16  dropped-frame counter.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, RECV, COMMIT, DROP, WAIT_DESC, DISCARD.
REQ-005 IDLE: begin_packet=1 -> RECV; start pointer latched = current write pointer (wp); length count len cleared; if data_ready=1 that cycle, byte written as byte 0.
REQ-006 RECV, data_ready=1: buf_wr_en=1, buf_wr_addr=wp, buf_wr_data=packet_data, same cycle (combinational from registered wp); wp increments modulo 2^ADDR_W; len increments.
REQ-007 RECV, end_packet=1: -> COMMIT if MIN_LEN <= len <= MAX_LEN, else -> DROP; any byte with data_ready in that cycle is written and counted first.
REQ-008 RECV: len reaching MAX_LEN+1 SHALL -> DISCARD (giant); writes stop.
REQ-009 RECV: write SHALL be suppressed and state -> DISCARD when used+len = 2^ADDR_W (buffer full); used = committed, unreleased bytes.
REQ-010 DISCARD: ignore all input until end_packet=1, then -> DROP.
REQ-011 DROP (1 cycle): wp restored to latched start pointer; frames_drop +1; -> IDLE.
REQ-012 COMMIT (1 cycle): if desc_valid=0, load desc_addr=start, desc_len=len, assert desc_valid, used += len, frames_ok +1, -> IDLE; if desc_valid=1, -> WAIT_DESC.
REQ-013 WAIT_DESC: perform COMMIT action on first cycle desc_valid=0, then -> IDLE; begin_packet seen here SHALL route that frame to DISCARD (-> counted as drop) after commit completes.
REQ-014 desc_valid SHALL stay high, desc_addr/desc_len stable, until cycle desc_ready=1; clears next cycle.
REQ-015 free_valid=1 SHALL reduce used by free_len same edge; simultaneous commit SHALL apply both (used + len - free_len).
REQ-016 free_len > used SHALL saturate used at 0.
REQ-017 Counters SHALL saturate at 16'hFFFF.
REQ-018 begin_packet while in RECV SHALL be treated as end of an aborted frame: -> DROP, new frame lost.

Reset
REQ-019 reset=0 SHALL immediately force: state IDLE, wp=0, used=0, len=0, buf_wr_en=0, desc_valid=0, desc_addr=0, desc_len=0, frames_ok=0, frames_drop=0.
REQ-020 Reset mid-frame SHALL abandon the frame with no descriptor and no counter update.

Verification
REQ-021 64-byte frame, desc_ready=1 -> 64 writes at addr 0..63, desc_valid with addr 0, len 64, frames_ok=1.
REQ-022 63-byte runt then 64-byte frame -> frames_drop=1, second frame desc_addr=0 (pointer rewound).
REQ-023 1519-byte frame -> 1518 writes, DISCARD, frames_drop=1, no descriptor, wp unchanged.
REQ-024 Two 100-byte frames, desc_ready=0 -> first descriptor held, second waits in WAIT_DESC; desc_ready pulse -> second descriptor addr 100, len 100.
REQ-025 Fill to used=2000 without free, send 100-byte frame -> 48 writes then DISCARD, drop; free_valid with free_len=2000 -> next 100-byte frame commits, wrapping addr 2000..51.
REQ-026 reset asserted at byte 30 of a frame -> all outputs zero immediately; next frame desc_addr=0.
